uart_rx_byte: RTL and testbench

UART_RX_BYTE -- requirements
Module: uart_rx_byte

---
 rtl/uart_rx_byte.sv | 132 +++++++++++++
 tb/tb_uart_rx_byte.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a one-byte valid/ready output holding register.
// Mid-bit sampling from a 2-flop synchronized line, frame error and sticky overrun.
module uart_rx_byte #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       ready,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int BIT_CLKS  = CLK_HZ / BAUD;
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam int CW        = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state;
    logic            rx_m;
    logic            rx_s;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // A commit later in this block overrides this consume.
            if (valid && ready)
                valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                            idx   <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        shreg[idx] <= rx_s;
                        idx        <= idx + 1'b1;
                        if (idx == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!valid || ready) begin
                                data_out <= shreg;
                                valid    <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at default 50 MHz / 115200 baud.
// Vector table for plain frames plus sequences for glitch, break, overrun, reset.
module tb_uart_rx_byte;
    localparam int BIT  = 50_000_000 / 115200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int failures = 0;

    logic [7:0] got_q[$];
    int vcyc = 0;
    int fe_cyc = 0;
    int fe_pulses = 0;
    logic fe_prev = 1'b0;

    uart_rx_byte dut (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .ready    (ready),
        .data_out (data_out),
        .valid    (valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid)
                vcyc++;
            if (valid && ready)
                got_q.push_back(data_out);
            if (frame_err)
                fe_cyc++;
            if (frame_err && !fe_prev)
                fe_pulses++;
            fe_prev = frame_err;
        end
    end

    initial begin
        repeat (200_000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clr();
        got_q.delete();
        vcyc = 0;
        fe_cyc = 0;
        fe_pulses = 0;
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++)
            send_bit(d[i]);
        send_bit(stp);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stp;
        int         exp_n;
        logic [7:0] exp_data;
        int         exp_fe;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{8'h48, 1'b1, 1, 8'h48, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[2] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
        vecs[3] = '{8'h3C, 1'b0, 0, 8'h00, 1};

        #1;
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_fe", 32'(frame_err), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            clr();
            send_byte(vecs[v].data, vecs[v].stp);
            send_bit(1'b1);
            chk($sformatf("v%0d_n", v), 32'(got_q.size()), 32'(vecs[v].exp_n));
            if (vecs[v].exp_n == 1 && got_q.size() == 1)
                chk($sformatf("v%0d_data", v), 32'(got_q[0]),
                    32'(vecs[v].exp_data));
            chk($sformatf("v%0d_vcyc", v), 32'(vcyc), 32'(vecs[v].exp_n));
            chk($sformatf("v%0d_fe", v), 32'(fe_pulses), 32'(vecs[v].exp_fe));
            chk($sformatf("v%0d_fecyc", v), 32'(fe_cyc), 32'(vecs[v].exp_fe));
            chk($sformatf("v%0d_ovr", v), 32'(overrun), 32'h0);
            chk($sformatf("v%0d_busy", v), 32'(busy), 32'h0);
        end

        // Short low pulse must be rejected at the half-bit check.
        clr();
        rx_in = 1'b0;
        repeat (50) @(negedge clk);
        chk("glitch_busy_hi", 32'(busy), 32'h1);
        repeat (50) @(negedge clk);
        rx_in = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("glitch_n", 32'(got_q.size()), 32'h0);
        chk("glitch_fe", 32'(fe_cyc), 32'h0);
        chk("glitch_busy", 32'(busy), 32'h0);

        // Bad stop bit followed by a 20-bit break.
        clr();
        send_byte(8'h6C, 1'b0);
        repeat (20 * BIT) @(negedge clk);
        chk("brk_fe", 32'(fe_pulses), 32'h1);
        chk("brk_fecyc", 32'(fe_cyc), 32'h1);
        chk("brk_n", 32'(got_q.size()), 32'h0);
        chk("brk_busy", 32'(busy), 32'h1);
        rx_in = 1'b1;
        repeat (8) @(negedge clk);
        chk("brk_busy_lo", 32'(busy), 32'h0);
        send_bit(1'b1);
        clr();
        send_byte(8'h21, 1'b1);
        send_bit(1'b1);
        chk("brk_next_n", 32'(got_q.size()), 32'h1);
        if (got_q.size() == 1)
            chk("brk_next_data", 32'(got_q[0]), 32'h21);
        chk("brk_next_fe", 32'(fe_cyc), 32'h0);

        // Overrun with consumer stalled.
        clr();
        ready = 1'b0;
        send_byte(8'h57, 1'b1);
        send_bit(1'b1);
        chk("ovr1_valid", 32'(valid), 32'h1);
        chk("ovr1_data", 32'(data_out), 32'h57);
        chk("ovr1_ovr", 32'(overrun), 32'h0);
        send_byte(8'h6F, 1'b1);
        send_bit(1'b1);
        chk("ovr2_valid", 32'(valid), 32'h1);
        chk("ovr2_data", 32'(data_out), 32'h57);
        chk("ovr2_ovr", 32'(overrun), 32'h1);
        ready = 1'b1;
        @(negedge clk);
        chk("ovr3_valid", 32'(valid), 32'h0);
        chk("ovr3_data", 32'(data_out), 32'h57);
        chk("ovr3_ovr", 32'(overrun), 32'h1);

        // Reset in the middle of data bit 4.
        clr();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++)
            send_bit(i[0]);
        rx_in = 1'b0;
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        rx_in = 1'b1;
        #1;
        chk("mrst_data", 32'(data_out), 32'h00);
        chk("mrst_valid", 32'(valid), 32'h0);
        chk("mrst_ovr", 32'(overrun), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
        chk("mrst_fe", 32'(frame_err), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send_bit(1'b1);
        chk("mrst_nocommit", 32'(got_q.size()), 32'h0);
        send_byte(8'hAA, 1'b1);
        send_bit(1'b1);
        chk("mrst_aa_n", 32'(got_q.size()), 32'h1);
        if (got_q.size() == 1)
            chk("mrst_aa_data", 32'(got_q[0]), 32'hAA);
        chk("mrst_aa_hold", 32'(data_out), 32'hAA);

        // Back-to-back frames, no idle gap.
        clr();
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_bit(1'b1);
        chk("b2b_n", 32'(got_q.size()), 32'h2);
        if (got_q.size() == 2) begin
            chk("b2b_d0", 32'(got_q[0]), 32'h55);
            chk("b2b_d1", 32'(got_q[1]), 32'hAA);
        end
        chk("b2b_vcyc", 32'(vcyc), 32'h2);
        chk("b2b_fe", 32'(fe_cyc), 32'h0);
        chk("b2b_ovr", 32'(overrun), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
